// File: rtl/logic_acc_if.sv
// logic_acc_if: word handshake and accumulator status bundle
// for the logic_acc block.
interface logic_acc_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] acc;
  logic             out_valid;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             any;
  logic             all;

  modport master (
    output in_valid, op, in_data,
    input  in_ready, acc, out_valid,
    input  count, full, any, all
  );

  modport slave (
    input  in_valid, op, in_data,
    output in_ready, acc, out_valid,
    output count, full, any, all
  );
endinterface

// File: rtl/logic_acc.sv
// logic_acc: bitwise OR/AND/XOR/LOAD accumulator with a
// saturating accepted-word counter and identity-aware clear.
module logic_acc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  logic_acc_if.slave bus
);
  typedef enum logic [1:0] {
    OP_OR   = 2'b00,
    OP_AND  = 2'b01,
    OP_XOR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             valid_q;
  logic             and_q;
  logic             full;
  logic             take;
  op_e              op;

  assign op   = op_e'(bus.op);
  assign full = (cnt_q == CNT_MAX);
  assign take = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !full && !clear && !reset;
  assign bus.acc       = acc_q;
  assign bus.count     = cnt_q;
  assign bus.out_valid = valid_q;
  assign bus.full      = full;
  assign bus.any       = |acc_q;
  assign bus.all       = &acc_q;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q + CNT_ONE;
    unique case (op)
      OP_OR:   acc_d = acc_q | bus.in_data;
      OP_AND:  acc_d = acc_q & bus.in_data;
      OP_XOR:  acc_d = acc_q ^ bus.in_data;
      OP_LOAD: begin
        acc_d = bus.in_data;
        cnt_d = CNT_ONE;
      end
    endcase
  end

  // clear restores the identity of the last accepted op,
  // so an AND chain restarts from all ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      and_q   <= 1'b0;
    end else if (clear) begin
      acc_q   <= {WIDTH{and_q}};
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= take;
      if (take) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        and_q <= (op == OP_AND);
      end
    end
  end
endmodule

// File: doc/logic_acc.md
LOGIC_ACC -- requirements
Module: logic_acc

Interface
REQ-001 The parameters SHALL be as follows, one per line: name, default, meaning.
- WIDTH, 16, data word width in bits (legal range 1..64).
- CNT_W, 4, width of the accepted-word counter (legal range 2..16).
REQ-002 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous accumulator clear, active-high.
- in_valid  in  1  input word offered.
- in_ready  out  1  block can accept a word this cycle.
- op  in  2  operation for the offered word: 00 OR, 01 AND, 10 XOR, 11 LOAD.
- in_data  in  WIDTH  operand word.
- acc  out  WIDTH  registered accumulator value.
- out_valid  out  1  one-cycle pulse: acc was updated by an accepted word on the previous edge.
- count  out  CNT_W  number of words accepted since the last reset, clear or LOAD.
- full  out  1  count equals 2^CNT_W-1.
- any  out  1  OR-reduction of acc.
- all  out  1  AND-reduction of acc.
REQ-003 The design SHALL have one clock; reset is synchronous and active-high.

Function
REQ-004 A word SHALL be accepted on a rising edge when in_valid=1 and in_ready=1.
REQ-005 in_ready SHALL equal (!full && !clear && !reset), combinationally.
REQ-006 On acceptance, acc SHALL become:
- acc|in_data for OR.
- acc&in_data for AND.
- acc^in_data for XOR.
- in_data for LOAD.
REQ-007 On acceptance, count SHALL increment by 1 for OR, AND and XOR, and SHALL become 1 for LOAD.
REQ-008 acc and count latency SHALL be one cycle: the new value is visible in the cycle after the accepting edge.
REQ-009 out_valid SHALL be 1 for exactly the cycle following each accepting edge, and 0 otherwise.
REQ-010 Back-to-back acceptances SHALL be supported at one word per cycle, with out_valid held high continuously.
REQ-011 When no word is accepted, acc and count SHALL hold their values.
REQ-012 full SHALL be 1 when count = 2^CNT_W-1. While full=1, in_ready=0, offered words are ignored, and acc and count are unchanged.
REQ-013 count SHALL never wrap.
REQ-014 A LOAD offered while full=1 SHALL be ignored; only clear or reset leaves the full state.
REQ-015 When clear=1, the next edge SHALL set the following, and no word is accepted in that cycle even if in_valid=1:
- acc: all 0 when the most recent op accepted was not AND.
- acc: all 1 when the most recent accepted op was AND (AND-identity).
- count = 0.
- out_valid = 0.
REQ-016 any, all and full SHALL be combinational functions of the registered acc and count.
REQ-017 in_data and op SHALL be sampled only on accepting edges.
REQ-018 X on in_data SHALL NOT corrupt state when in_valid=0.
REQ-019 For WIDTH=1, any and all SHALL both equal acc[0].

Reset
REQ-020 On any rising edge with reset=1, the following SHALL hold, and reset SHALL take priority over clear and in_valid:
- acc = 0.
- count = 0.
- out_valid = 0.
- The most-recent-op record = OR.
REQ-021 After reset, the following SHALL hold: full=0, any=0, all=0 (for WIDTH>1), and in_ready=1 once reset is released.
REQ-022 Assertion of reset mid-stream SHALL discard any in-progress accumulation with no partial update.

Verification
REQ-023 The bench SHALL cover at least the following directed scenarios (WIDTH=16, CNT_W=4 unless stated):
- Reset, then OR-accept 0x0001, 0x0002, 0x0004, 0x0008 -> acc=0x000F, count=4, any=1, all=0, out_valid high for 4 consecutive cycles.
- LOAD 0xFFFF, then AND 0x0F0F -> acc=0x0F0F, count=2; then XOR 0x00FF -> acc=0x0FF0, count=3.
- 15 OR-accepts of 0x0001 -> full=1, in_ready=0; a 16th word 0xFFFF is ignored, so acc=0x0001, count=15.
- clear=1 and in_valid=1 in the same cycle after AND accepts -> acc=0xFFFF, count=0, out_valid=0 next cycle, word dropped.
- reset asserted during a burst -> acc=0, count=0 on that edge; the next accepted OR 0x8000 gives acc=0x8000.
- Parameter sweep WIDTH=1 and WIDTH=64 -> random op/in_data streams match a bit-exact reference model every cycle.
